multi_range_tracker: RTL and testbench

- Parametrised successor to the single-channel go/finish range block on the 12-in/12-out tinytapeout wrapper.
- Tracks running min, max and saturating sample count for NUM_CH independent channels over a go..finish window.
- Adds a valid qualifier, a channel tag, four readout modes and a registered, held result.
- Result drives seg7 (DATA_W=4) or wider consumers.

---
 rtl/range_pkg.sv | 5 +
 rtl/minmax_cell.sv | 44 ++++
 rtl/multi_range_tracker.sv | 125 ++++++++++++
 tb/tb_multi_range_tracker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared types for the multi-channel range tracker: FSM state and readout mode encodings.
package range_pkg;
  typedef enum logic [1:0] {IDLE, TRACK, DONE, ERROR} state_t;
  typedef enum logic [1:0] {MODE_RANGE, MODE_MIN, MODE_MAX, MODE_COUNT} mode_t;
endpackage

// File: rtl/minmax_cell.sv
// One channel of running min/max plus saturating sample count over a tracking window.
module minmax_cell #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] low,
  output logic [DATA_W-1:0] high,
  output logic [DATA_W-1:0] count,
  output logic              seen
);
  logic [DATA_W-1:0] r_low, r_high, r_count;
  logic              r_seen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_low   <= '0;
      r_high  <= '0;
      r_count <= '0;
      r_seen  <= 1'b0;
    end else if (sample_en && (clear || !r_seen)) begin
      // A sample in the window-start cycle becomes the first sample of the new window.
      r_low   <= data;
      r_high  <= data;
      r_count <= DATA_W'(1);
      r_seen  <= 1'b1;
    end else if (sample_en) begin
      if (data < r_low)  r_low  <= data;
      if (data > r_high) r_high <= data;
      if (r_count != '1) r_count <= r_count + 1'b1;
    end else if (clear) begin
      r_count <= '0;
      r_seen  <= 1'b0;
    end
  end

  assign low   = r_low;
  assign high  = r_high;
  assign count = r_count;
  assign seen  = r_seen;
endmodule

// File: rtl/multi_range_tracker.sv
// Multi-channel go/finish range tracker with tagged samples and registered readout.
// Define STICKY_ERROR_EN to make the error flag sticky until reset.
module multi_range_tracker
  import range_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 2,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              finish,
  input  logic              valid,
  input  logic [CH_W-1:0]   ch_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              ch_empty,
  output logic              busy,
  output logic              error
);
  state_t            r_state;
  state_t            w_next;
  logic              r_busy, r_error, r_result_valid, r_ch_empty;
  logic [DATA_W-1:0] r_result;

  logic [DATA_W-1:0] w_low   [NUM_CH];
  logic [DATA_W-1:0] w_high  [NUM_CH];
  logic [DATA_W-1:0] w_count [NUM_CH];
  logic [NUM_CH-1:0] w_seen;

  // finish beats go everywhere except ERROR, where go is the only way out.
  logic w_go_acc, w_samp, w_stay_done;
  assign w_go_acc    = go && ((r_state == ERROR) || !finish);
  assign w_samp      = valid && (int'(ch_in) < NUM_CH) && ((r_state == TRACK) || w_go_acc);
  assign w_stay_done = (r_state == DONE) && (w_next == DONE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    minmax_cell #(.DATA_W(DATA_W)) u_cell (
      .clock     (clock),
      .reset     (reset),
      .clear     (w_go_acc),
      .sample_en (w_samp && (ch_in == CH_W'(c))),
      .data      (data_in),
      .low       (w_low[c]),
      .high      (w_high[c]),
      .count     (w_count[c]),
      .seen      (w_seen[c])
    );
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (finish) w_next = ERROR; else if (go) w_next = TRACK;
      TRACK:      if (finish) w_next = DONE;  else if (go) w_next = TRACK;
      ERROR:      if (go) w_next = TRACK;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == TRACK);
`ifdef STICKY_ERROR_EN
      r_error <= r_error | (w_next == ERROR);
`else
      r_error <= (w_next == ERROR);
`endif
    end
  end

  logic              w_rd_ok, w_empty;
  logic [DATA_W-1:0] w_sel_low, w_sel_high, w_sel_count, w_mux;

  always_comb begin
    w_rd_ok     = int'(rd_ch) < NUM_CH;
    w_sel_low   = '0;
    w_sel_high  = '0;
    w_sel_count = '0;
    w_empty     = 1'b1;
    if (w_rd_ok) begin
      w_sel_low   = w_low[rd_ch];
      w_sel_high  = w_high[rd_ch];
      w_sel_count = w_count[rd_ch];
      w_empty     = !w_seen[rd_ch];
    end
    case (mode_t'(mode))
      MODE_RANGE: w_mux = w_sel_high - w_sel_low;
      MODE_MIN:   w_mux = w_sel_low;
      MODE_MAX:   w_mux = w_sel_high;
      default:    w_mux = w_sel_count;
    endcase
  end

  // Readout refreshes only while DONE persists; leaving DONE freezes result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_ch_empty     <= 1'b0;
    end else if (w_stay_done) begin
      r_result       <= w_empty ? '0 : w_mux;
      r_result_valid <= 1'b1;
      r_ch_empty     <= w_empty;
    end else begin
      r_result_valid <= 1'b0;
      r_ch_empty     <= 1'b0;
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign ch_empty     = r_ch_empty;
  assign busy         = r_busy;
  assign error        = r_error;
endmodule

// File: tb/tb_multi_range_tracker.sv
// Directed self-checking bench for multi_range_tracker (DATA_W=4, NUM_CH=2).
module tb_multi_range_tracker;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0, finish = 1'b0, valid = 1'b0;
  logic [0:0] ch_in = '0, rd_ch = '0;
  logic [3:0] data_in = '0;
  logic [1:0] mode = 2'd0;
  logic [3:0] result;
  logic       result_valid, ch_empty, busy, error;
  int checks = 0;
  int errors = 0;

`ifdef STICKY_ERROR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  always #5 clock = ~clock;

  multi_range_tracker #(.DATA_W(4), .NUM_CH(2)) dut (
    .clock(clock), .reset(reset), .go(go), .finish(finish), .valid(valid),
    .ch_in(ch_in), .data_in(data_in), .rd_ch(rd_ch), .mode(mode),
    .result(result), .result_valid(result_valid), .ch_empty(ch_empty),
    .busy(busy), .error(error)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input logic [0:0] ch, input logic [3:0] d);
    valid = 1'b1; ch_in = ch; data_in = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic read(input logic [0:0] ch, input logic [1:0] m, input logic [3:0] exp_r,
                      input logic exp_e, input string name);
    rd_ch = ch; mode = m;
    tick();
    checks++;
    if (result !== exp_r || ch_empty !== exp_e || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: result=%0d ch_empty=%b rv=%b, expected result=%0d ch_empty=%b rv=1",
               name, result, ch_empty, result_valid, exp_r, exp_e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({result, result_valid, ch_empty, busy, error} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got r=%0d rv=%b ce=%b b=%b e=%b, expected all 0",
               result, result_valid, ch_empty, busy, error);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    sample(0, 5); sample(0, 2); sample(0, 9);
    finish = 1'b1; rd_ch = 0; mode = 2'd0; tick(); finish = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: rv=%b busy=%b, expected rv=0 busy=0", result_valid, busy);
    end
    read(0, 2'd0, 4'd7, 1'b0, "basic_range");
    read(0, 2'd1, 4'd2, 1'b0, "basic_min");
    read(0, 2'd2, 4'd9, 1'b0, "basic_max");
    read(0, 2'd3, 4'd3, 1'b0, "basic_count");
  endtask

  task automatic test_same_cycle();
    go = 1'b1; valid = 1'b1; ch_in = 1; data_in = 4'd6; tick(); go = 1'b0; valid = 1'b0;
    sample(1, 4);
    finish = 1'b1; sample(1, 12); finish = 1'b0;
    read(1, 2'd0, 4'd8, 1'b0, "ch1_range");
    read(1, 2'd3, 4'd3, 1'b0, "ch1_count");
    read(0, 2'd0, 4'd0, 1'b1, "ch0_empty");
  endtask

  task automatic test_error();
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    finish = 1'b1; tick(); finish = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL error_set: e=%b b=%b rv=%b, expected e=1 b=0 rv=0", error, busy, result_valid);
    end
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if (error !== STICKY || busy !== 1'b1) begin
      errors++;
      $display("FAIL error_after_go: e=%b b=%b, expected e=%b b=1", error, busy, STICKY);
    end
  endtask

  task automatic test_saturate();
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 17; i++) sample(0, 3);
    finish = 1'b1; tick(); finish = 1'b0;
    read(0, 2'd3, 4'd15, 1'b0, "sat_count");
    read(0, 2'd0, 4'd0, 1'b0, "sat_range");
  endtask

  task automatic test_back_to_back();
    go = 1'b1; tick(); go = 1'b0;
    sample(0, 1); sample(0, 14);
    go = 1'b1; finish = 1'b1; tick(); go = 1'b0; finish = 1'b0;
    read(0, 2'd0, 4'd13, 1'b0, "finish_wins_range");
    go = 1'b1; tick(); go = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || result !== 4'd13 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_done: rv=%b r=%0d b=%b, expected rv=0 r=13 b=1",
               result_valid, result, busy);
    end
    finish = 1'b1; tick(); finish = 1'b0;
    read(0, 2'd0, 4'd0, 1'b1, "cleared_empty");
  endtask

  task automatic test_mid_reset();
    go = 1'b1; tick(); go = 1'b0;
    sample(0, 8); sample(0, 3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({result, result_valid, ch_empty, busy, error} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: r=%0d rv=%b ce=%b b=%b e=%b, expected all 0",
               result, result_valid, ch_empty, busy, error);
    end
    reset = 1'b0;
    tick();
    go = 1'b1; tick(); go = 1'b0;
    sample(0, 5);
    finish = 1'b1; tick(); finish = 1'b0;
    read(0, 2'd0, 4'd0, 1'b0, "post_reset_range");
    read(0, 2'd1, 4'd5, 1'b0, "post_reset_min");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_error();
    test_saturate();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
